// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, enums and request payload for the
// data-memory arbiter (core load/store port vs. external DMA port).
// No ports; imported by the interface, the arbiter and its sub-module.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_MASK_W = 4;
  localparam int unsigned STARVE_CNT_W = 3;

  // Which requester owns the read response due next cycle
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DMA
  } owner_e;

  typedef enum logic {
    ARB,
    LOCKED
  } state_e;

  typedef struct packed {
    logic                   wr;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_MASK_W-1:0] mask;
  } req_t;

  localparam req_t REQ_IDLE = '0;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the core port, DMA port and memory port.
//   slave  : arbiter view (requests/mem_rdata in; grants, read data, mem_* out)
//   master : requester + memory view (the opposite directions)
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  // core load/store port
  logic                   core_req;
  logic                   core_wr;
  logic [DMEM_ADDR_W-1:0] core_addr;
  logic [DMEM_DATA_W-1:0] core_wdata;
  logic [DMEM_MASK_W-1:0] core_mask;
  logic                   core_gnt;
  logic                   core_stall;
  logic                   core_rvalid;
  logic [DMEM_DATA_W-1:0] core_rdata;

  // DMA port
  logic                   dma_req;
  logic                   dma_wr;
  logic                   dma_lock;
  logic [DMEM_ADDR_W-1:0] dma_addr;
  logic [DMEM_DATA_W-1:0] dma_wdata;
  logic [DMEM_MASK_W-1:0] dma_mask;
  logic                   dma_gnt;
  logic                   dma_rvalid;
  logic [DMEM_DATA_W-1:0] dma_rdata;

  // single-ported data memory
  logic                   mem_cs;
  logic                   mem_wr;
  logic [DMEM_ADDR_W-1:0] mem_addr;
  logic [DMEM_DATA_W-1:0] mem_wdata;
  logic [DMEM_MASK_W-1:0] mem_mask;
  logic [DMEM_DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_wr, core_addr, core_wdata, core_mask,
    input  dma_req, dma_wr, dma_lock, dma_addr, dma_wdata, dma_mask,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_cs, mem_wr, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output core_req, core_wr, core_addr, core_wdata, core_mask,
    output dma_req, dma_wr, dma_lock, dma_addr, dma_wdata, dma_mask,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_cs, mem_wr, mem_addr, mem_wdata, mem_mask
  );

endinterface

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: saturating count of consecutive cycles the DMA waited
// while requesting; raises force_o once the count reaches STARVE_MAX.
//   clk, reset  : clock, async active-high reset
//   dma_req_i   : DMA is requesting this cycle
//   dma_gnt_i   : DMA was granted this cycle
//   force_o     : DMA must win arbitration this cycle
module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_o
);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Count waiting cycles; any grant or dropped request restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Driven from the register only, so no loop through the grant logic
  assign force_o = (cnt_q == STARVE_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core
// load/store path and a DMA requester. Core has priority; DMA can hold
// ownership (LOCKED) for atomic bursts. Read data returns one cycle after
// the grant to whichever requester issued the read.
//   clk, reset : clock, async active-high reset
//   bus        : dmem_arbiter_if.slave (core port, DMA port, memory port)
// Build option DMEM_ARB_STARVE_EN: when defined, a DMA that has waited
// STARVE_MAX consecutive cycles wins over the core; when undefined the
// core has strict priority in ARB.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
`ifdef DMEM_ARB_STARVE_EN
#(
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  state_e state_q;
  owner_e owner_q;
  logic   core_gnt;
  logic   dma_gnt;
  logic   dma_force;
  req_t   core_r;
  req_t   dma_r;
  req_t   win_r;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .dma_req_i (bus.dma_req),
    .dma_gnt_i (dma_gnt),
    .force_o   (dma_force)
  );
`else
  assign dma_force = 1'b0;
`endif

  // Grants: zero-latency, one-hot or zero
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.core_req && !(bus.dma_req && dma_force)) begin
          core_gnt = 1'b1;
        end else if (bus.dma_req) begin
          dma_gnt = 1'b1;
        end
      end
      LOCKED: dma_gnt = bus.dma_req;
      default: ;
    endcase
  end

  // Ownership FSM; lock release needs no grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
    end else begin
      case (state_q)
        ARB:     if (dma_gnt && bus.dma_lock) state_q <= LOCKED;
        LOCKED:  if (!bus.dma_lock)           state_q <= ARB;
        default: state_q <= ARB;
      endcase
    end
  end

  // Remember who issued the read so next cycle's mem_rdata is routed there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else if (core_gnt && !bus.core_wr) begin
      owner_q <= OWN_CORE;
    end else if (dma_gnt && !bus.dma_wr) begin
      owner_q <= OWN_DMA;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  assign core_r = '{wr: bus.core_wr, addr: bus.core_addr,
                    wdata: bus.core_wdata, mask: bus.core_mask};
  assign dma_r  = '{wr: bus.dma_wr, addr: bus.dma_addr,
                    wdata: bus.dma_wdata, mask: bus.dma_mask};

  // Idle memory port is driven fully to zero
  always_comb begin
    win_r = REQ_IDLE;
    if (core_gnt) begin
      win_r = core_r;
    end else if (dma_gnt) begin
      win_r = dma_r;
    end
  end

  assign bus.mem_cs    = core_gnt | dma_gnt;
  assign bus.mem_wr    = win_r.wr;
  assign bus.mem_addr  = win_r.addr;
  assign bus.mem_wdata = win_r.wdata;
  assign bus.mem_mask  = win_r.mask;

  assign bus.core_gnt    = core_gnt;
  assign bus.dma_gnt     = dma_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;

  assign bus.core_rvalid = (owner_q == OWN_CORE);
  assign bus.dma_rvalid  = (owner_q == OWN_DMA);
  assign bus.core_rdata  = (owner_q == OWN_CORE) ? bus.mem_rdata : '0;
  assign bus.dma_rdata   = (owner_q == OWN_DMA)  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter with a per-cycle
// scoreboard; stimulus pushes the expected outputs, a negedge monitor pops
// and compares. Includes a small byte-masked memory model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: writes commit at the posedge, read data valid next cycle
  logic [31:0] mem [0:63];
  logic [31:0] mem_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]      <= 32'hA5A5A5A5;  // 0x10
      mem[8]      <= 32'hDEADBEEF;  // 0x20
      mem[9]      <= 32'h00002424;  // 0x24
      mem[17]     <= 32'h11111111;  // 0x44
      mem_rdata_q <= 32'h0;
    end else if (bus.mem_cs) begin
      if (bus.mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask[b])
            mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        mem_rdata_q <= mem[bus.mem_addr[7:2]];
      end
    end
  end

  typedef struct {
    logic        cg, dg, stall, cs, wr;
    logic [3:0]  mask;
    logic [31:0] addr, wdata;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   vec    = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", n, vec, act, req);
    end
  endfunction

  // Monitor: compares every cycle for which stimulus left an expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("core_gnt",    32'(bus.core_gnt),    32'(mon_e.cg));
      chk("dma_gnt",     32'(bus.dma_gnt),     32'(mon_e.dg));
      chk("core_stall",  32'(bus.core_stall),  32'(mon_e.stall));
      chk("mem_cs",      32'(bus.mem_cs),      32'(mon_e.cs));
      chk("mem_wr",      32'(bus.mem_wr),      32'(mon_e.wr));
      chk("mem_mask",    32'(bus.mem_mask),    32'(mon_e.mask));
      chk("mem_addr",    bus.mem_addr,         mon_e.addr);
      chk("mem_wdata",   bus.mem_wdata,        mon_e.wdata);
      chk("core_rvalid", 32'(bus.core_rvalid), 32'(mon_e.crv));
      chk("core_rdata",  bus.core_rdata,       mon_e.crd);
      chk("dma_rvalid",  32'(bus.dma_rvalid),  32'(mon_e.drv));
      chk("dma_rdata",   bus.dma_rdata,        mon_e.drd);
      vec++;
    end
  end

  task automatic set_core(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
    bus.core_req   = req;
    bus.core_wr    = wr;
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
    bus.core_mask  = mask;
  endtask

  task automatic set_dma(input logic req, input logic wr, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
    bus.dma_req   = req;
    bus.dma_wr    = wr;
    bus.dma_lock  = lock;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
    bus.dma_mask  = mask;
  endtask

  // Push the expectation for the current cycle, then advance one cycle
  task automatic step(input logic cg, input logic dg, input logic cs, input logic wr,
                      input logic [3:0] mask, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic crv, input logic [31:0] crd,
                      input logic drv, input logic [31:0] drd);
    exp_t e;
    e.cg = cg; e.dg = dg; e.cs = cs; e.wr = wr; e.mask = mask;
    e.addr = addr; e.wdata = wdata;
    e.crv = crv; e.crd = crd; e.drv = drv; e.drd = drd;
    e.stall = bus.core_req & ~cg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step_rv(input logic crv, input logic [31:0] crd,
                         input logic drv, input logic [31:0] drd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, crv, crd, drv, drd);
  endtask

  task automatic step0();
    step_rv(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  logic dwin, prev_dwin, pcore, pdma;

  initial begin
    reset = 1'b1;
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    set_dma(0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;

    // Reset state with no requests
    step0();
    reset = 1'b0;
    step0();

    // Core read 0x20 alone
    set_core(1, 0, 32'h20, 32'h0, 4'hF);
    step(1, 0, 1, 0, 4'hF, 32'h20, 32'h0, 0, 32'h0, 0, 32'h0);
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(1, 32'hDEADBEEF, 0, 32'h0);

    // Both requesting continuously: starvation guard decides the 5th cycle
    set_core(1, 0, 32'h20, 32'h0, 4'hF);
    set_dma(1, 0, 0, 32'h24, 32'h0, 4'hF);
    prev_dwin = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_STARVE_EN
      dwin = (i == 4);
`else
      dwin = 1'b0;
`endif
      pcore = (i > 0) && !prev_dwin;
      pdma  = prev_dwin;
      step(!dwin, dwin, 1, 0, 4'hF, dwin ? 32'h24 : 32'h20, 32'h0,
           pcore, pcore ? 32'hDEADBEEF : 32'h0, pdma, pdma ? 32'h00002424 : 32'h0);
      prev_dwin = dwin;
    end
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    set_dma(0, 0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(1, 32'hDEADBEEF, 0, 32'h0);

    // Core read in flight while DMA locks with a write to 0x40
    set_core(1, 0, 32'h20, 32'h0, 4'hF);
    step(1, 0, 1, 0, 4'hF, 32'h20, 32'h0, 0, 32'h0, 0, 32'h0);
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    set_dma(1, 1, 1, 32'h40, 32'h12345678, 4'hF);
    step(0, 1, 1, 1, 4'hF, 32'h40, 32'h12345678, 1, 32'hDEADBEEF, 0, 32'h0);
    // Locked, no DMA request: core stalls
    set_dma(0, 0, 1, 32'h0, 32'h0, 4'h0);
    set_core(1, 0, 32'h40, 32'h0, 4'hF);
    step0();
    step0();
    // Locked DMA read beats the core
    set_dma(1, 0, 1, 32'h24, 32'h0, 4'hF);
    step(0, 1, 1, 0, 4'hF, 32'h24, 32'h0, 0, 32'h0, 0, 32'h0);
    // Lock drops: still locked this cycle, ARB from next
    set_dma(0, 0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(0, 32'h0, 1, 32'h00002424);
    step(1, 0, 1, 0, 4'hF, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0);
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(1, 32'h12345678, 0, 32'h0);

    // Core read then DMA read back-to-back, no cross-delivery
    set_core(1, 0, 32'h20, 32'h0, 4'hF);
    set_dma(1, 0, 0, 32'h24, 32'h0, 4'hF);
    step(1, 0, 1, 0, 4'hF, 32'h20, 32'h0, 0, 32'h0, 0, 32'h0);
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    step(0, 1, 1, 0, 4'hF, 32'h24, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
    set_dma(0, 0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(0, 32'h0, 1, 32'h00002424);

    // Core byte write mask 0x2 to 0x44, then read back
    set_core(1, 1, 32'h44, 32'h0000AB00, 4'h2);
    step(1, 0, 1, 1, 4'h2, 32'h44, 32'h0000AB00, 0, 32'h0, 0, 32'h0);
    set_core(1, 0, 32'h44, 32'h0, 4'hF);
    step(1, 0, 1, 0, 4'hF, 32'h44, 32'h0, 0, 32'h0, 0, 32'h0);
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    step_rv(1, 32'h1111AB11, 0, 32'h0);

    // Reset mid-read of 0x10: response suppressed
    set_core(1, 0, 32'h10, 32'h0, 4'hF);
    step(1, 0, 1, 0, 4'hF, 32'h10, 32'h0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    set_core(0, 0, 32'h0, 32'h0, 4'h0);
    step0();
    reset = 1'b0;
    step0();
    step0();

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-ported data memory between the pipeline load/store path (core port) and an external DMA requester. Sits between the core's load/store address/sizing logic and the data memory; issues at most one memory access per cycle, returns read data to the owning requester one cycle later, and stalls the core when it loses arbitration. Core has priority, bounded by an optional DMA starvation guard and a DMA lock mode for atomic bursts.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive DMA wait cycles before DMA is forced to win (1..7)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- core_req / core_wr  in  1 / 1  core access request / write (1) or read (0)
- core_addr / core_wdata / core_mask  in  ADDR_W / DATA_W / 4  core address, store data, byte mask
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req && !core_gnt
- core_rvalid / core_rdata  out  1 / DATA_W  core read data valid, data
- dma_req / dma_wr / dma_lock  in  1 / 1 / 1  DMA request, write, hold-ownership
- dma_addr / dma_wdata / dma_mask  in  ADDR_W / DATA_W / 4  DMA address, data, mask
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid / dma_rdata  out  1 / DATA_W  DMA read data valid, data
- mem_cs / mem_wr  out  1 / 1  memory chip select, write enable
- mem_addr / mem_wdata / mem_mask  out  ADDR_W / DATA_W / 4  muxed to memory
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read select

## Operation
- FSM states: ARB, LOCKED.
- ARB: if only one req, grant it. Both req: core wins unless starve_cnt == STARVE_MAX (DMA wins).
- ARB -> LOCKED when dma_gnt && dma_lock. LOCKED: core never granted; DMA granted whenever dma_req. LOCKED -> ARB when dma_lock == 0 (sampled at posedge; no grant required).
- starve_cnt (3-bit, saturating): +1 each cycle dma_req && !dma_gnt; clear on dma_gnt or !dma_req.
- Grants combinational, one-hot or zero. mem_cs = core_gnt | dma_gnt; mem_* muxed from winner; when idle mem_cs = 0, mem_wr = 0, mem_mask = 0, mem_addr/wdata = 0.
- Read owner register: on a granted read, latch owner (CORE/DMA). Next cycle: owner's rvalid = 1, rdata = mem_rdata; other port's rdata holds 0.
- Requesters hold req/addr/data stable until their gnt; keeping req high after gnt is a new back-to-back access.

## Timing
- Reset values: state ARB, starve_cnt 0, owner cleared, core_rvalid = dma_rvalid = 0, core_rdata = dma_rdata = 0; all grant/mem outputs 0 while no requests.
- Grant latency 0 cycles (same cycle as req when winning). Writes commit at the posedge ending the grant cycle. Read latency 1 cycle (rvalid the cycle after gnt).
- Back-to-back reads from alternating requesters: each rvalid appears exactly once, one cycle after its gnt, no bubbles.
- Read in flight when entering LOCKED: its response still delivered to the core.
- Reset mid-read: rvalid forced 0 immediately; no response after reset release.
- dma_lock with no dma_req in LOCKED: no grants, core stalls until lock drops.

## Configuration
- DMEM_ARB_STARVE_EN: defined -> starvation counter and forced DMA win as above. Undefined -> counter absent, strict core priority in ARB (DMA may starve indefinitely); LOCKED unaffected.

## Structure
- Shared package: owner enum (OWN_NONE, OWN_CORE, OWN_DMA), FSM state enum (ARB, LOCKED), request struct {wr, addr, wdata, mask}.
- One sub-module natural: dmem_arb_starve (saturating wait counter + force flag), instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset, no reqs -> all outputs 0, mem_cs 0; assert reset mid-read of addr 0x10 -> rvalid stays 0.
- Core read 0x20 alone (mem holds 0xDEADBEEF) -> core_gnt same cycle, core_rvalid with 0xDEADBEEF next cycle, dma_rvalid 0.
- Both request continuously, STARVE_MAX = 4, macro on -> core granted 4 cycles, DMA granted cycle 5, counter clears; macro off -> DMA never granted, core_stall never set.
- DMA write 0x40 = 0x12345678 mask 0xF with dma_lock = 1, then core read 0x40 -> core stalled until lock drops, then reads 0x12345678.
- Core read granted cycle N, DMA read granted cycle N+1 -> core_rvalid at N+1, dma_rvalid at N+2, correct data each, no cross-delivery.
- Core byte write mask 0x2 to 0x44 -> mem_mask = 0x2, mem_wr = 1 for exactly one cycle.
